// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone B3 arbiter: grants the wb_io port to one master per cyc period
// and terminates accesses that no peripheral answers within TIMEOUT cycles.
module wb_io_arbiter #(
    parameter int num_masters = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [32*num_masters-1:0] wbm_adr_i,
    input  logic [32*num_masters-1:0] wbm_dat_i,
    input  logic [4*num_masters-1:0]  wbm_sel_i,
    input  logic [num_masters-1:0]    wbm_we_i,
    input  logic [num_masters-1:0]    wbm_cyc_i,
    input  logic [num_masters-1:0]    wbm_stb_i,
    input  logic [3*num_masters-1:0]  wbm_cti_i,
    input  logic [2*num_masters-1:0]  wbm_bte_i,
    output logic [32*num_masters-1:0] wbm_dat_o,
    output logic [num_masters-1:0]    wbm_ack_o,
    output logic [num_masters-1:0]    wbm_err_o,
    output logic [num_masters-1:0]    wbm_rty_o,
    output logic [31:0]               wbs_adr_o,
    output logic [31:0]               wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [31:0]               wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [num_masters-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int LW = (num_masters > 1) ? $clog2(num_masters) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [num_masters-1:0] ONE = {{(num_masters-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state, w_state_nxt;
    logic [LW-1:0]          r_gidx, r_last, w_pick;
    logic [num_masters-1:0] r_grant;
    logic [CW-1:0]          r_cnt;
    logic                   r_timeout;
    logic                   w_any, w_gcyc, w_resp, w_fire;

    // Round-robin search starting just above the previous owner.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int unsigned i = 1; i <= num_masters; i++) begin
            if (!w_any && wbm_cyc_i[LW'((32'(r_last) + i) % num_masters)]) begin
                w_any  = 1'b1;
                w_pick = LW'((32'(r_last) + i) % num_masters);
            end
        end
    end

    assign w_gcyc = wbm_cyc_i[r_gidx];
    assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_fire = (r_state == BUSY) && w_gcyc && wbs_stb_o && !w_resp && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)   w_state_nxt = BUSY;
            BUSY:    if (!w_gcyc) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (r_state == BUSY) begin
            wbs_adr_o = wbm_adr_i[32*r_gidx +: 32];
            wbs_dat_o = wbm_dat_i[32*r_gidx +: 32];
            wbs_sel_o = wbm_sel_i[4*r_gidx +: 4];
            wbs_we_o  = wbm_we_i[r_gidx];
            wbs_cyc_o = w_gcyc;
            wbs_stb_o = wbm_stb_i[r_gidx] & ~r_timeout;
            wbs_cti_o = wbm_cti_i[3*r_gidx +: 3];
            wbs_bte_o = wbm_bte_i[2*r_gidx +: 2];
            // Late slave responses in the timeout cycle are dropped; only err goes back.
            wbm_ack_o = r_grant & {num_masters{wbs_ack_i & ~r_timeout}};
            wbm_rty_o = r_grant & {num_masters{wbs_rty_i & ~r_timeout}};
            wbm_err_o = r_grant & {num_masters{wbs_err_i | r_timeout}};
        end
    end

    assign wbm_dat_o = {num_masters{wbs_dat_i}};
    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= LW'(num_masters - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_fire;
            if (r_state == IDLE && w_any) begin
                r_gidx  <= w_pick;
                r_grant <= ONE << w_pick;
            end else if (r_state == BUSY && !w_gcyc) begin
                r_grant <= '0;
                r_last  <= r_gidx;
            end
            if (r_state != BUSY || w_resp || !wbs_stb_o || w_fire)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Directed bench for wb_io_arbiter: per-cycle comparison against a behavioural
// owner/wait-age model plus hand-computed checkpoints for each scenario.
module tb_wb_io_arbiter;

    localparam int NM = 3;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*NM-1:0]  m_adr, m_dat, m_dat_o;
    logic [4*NM-1:0]   m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb, m_ack, m_err, m_rty, grant;
    logic [3*NM-1:0]   m_cti;
    logic [2*NM-1:0]   m_bte;
    logic [31:0]       s_adr, s_dat_o, s_dat_i;
    logic [3:0]        s_sel;
    logic              s_we, s_cyc, s_stb, s_ack, s_err, s_rty, tmo;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              auto_ack, man_ack;

    int n_total = 0;
    int n_bad   = 0;

    assign s_ack = auto_ack ? s_stb : man_ack;

    always #5 clk = ~clk;

    wb_io_arbiter #(.num_masters(NM), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: who owns the bus, which master went last, and how many cycles the
    // current strobe has been waiting unanswered.
    int m_owner = -1;
    int m_last  = NM - 1;
    int m_wait  = 0;
    bit m_to    = 0;
    bit chk_en  = 0;

    always @(negedge clk) begin
        logic [NM-1:0] e_grant, e_ack, e_err, e_rty, sel1;
        logic [75:0]   e_bus;
        logic          e_stb;
        bit            busy, resp, to_n;
        int            o;
        busy  = (m_owner >= 0);
        o     = busy ? m_owner : 0;
        sel1  = NM'(1) << o;
        e_stb = busy && m_stb[o] && !m_to;
        resp  = s_ack || s_err || s_rty;
        e_grant = busy ? sel1 : '0;
        e_ack   = (busy && s_ack && !m_to) ? sel1 : '0;
        e_rty   = (busy && s_rty && !m_to) ? sel1 : '0;
        e_err   = (busy && (s_err || m_to)) ? sel1 : '0;
        e_bus   = busy ? {m_adr[32*o +: 32], m_dat[32*o +: 32], m_sel[4*o +: 4], m_we[o],
                          m_cyc[o], e_stb, m_cti[3*o +: 3], m_bte[2*o +: 2]} : '0;
        if (chk_en) begin
            chk("grant", 128'(grant), 128'(e_grant));
            chk("slave_bus", 128'({s_adr, s_dat_o, s_sel, s_we, s_cyc, s_stb, s_cti, s_bte}), 128'(e_bus));
            chk("responses", 128'({m_ack, m_err, m_rty}), 128'({e_ack, e_err, e_rty}));
            chk("timeout", 128'(tmo), 128'(m_to));
            chk("read_data", 128'(m_dat_o), 128'({NM{s_dat_i}}));
        end
        if (rst) begin
            m_owner = -1; m_last = NM - 1; m_wait = 0; m_to = 0; chk_en = 1;
        end else begin
            to_n   = busy && m_cyc[o] && e_stb && !resp && (m_wait + 1 == TO);
            m_wait = (busy && e_stb && !resp && !to_n) ? m_wait + 1 : 0;
            m_to   = to_n;
            if (!busy) begin
                for (int k = 1; k <= NM; k++)
                    if (m_owner < 0 && m_cyc[(m_last + k) % NM]) m_owner = (m_last + k) % NM;
            end else if (!m_cyc[o]) begin
                m_last  = o;
                m_owner = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_m(input int m, input logic c, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [2:0] cti);
        m_cyc[m] = c;
        m_stb[m] = s;
        m_we[m]  = w;
        m_adr[32*m +: 32] = a;
        m_dat[32*m +: 32] = d;
        m_sel[4*m +: 4]   = 4'hF;
        m_cti[3*m +: 3]   = cti;
        m_bte[2*m +: 2]   = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [NM-1:0] glog[$];

    // Each master in mask completes n_each single transfers, dropping cyc for one
    // cycle after every ack; the slave acks any strobe immediately.
    task automatic run_rr(input logic [NM-1:0] mask, input int n_each);
        int            rem[NM];
        bit            drop[NM];
        bit            done;
        bit            want;
        logic [NM-1:0] prev;
        glog.delete();
        prev = '0;
        done = 0;
        auto_ack = 1'b1;
        for (int m = 0; m < NM; m++) begin
            rem[m]  = mask[m] ? n_each : 0;
            drop[m] = 0;
        end
        for (int c = 0; c < 200; c++) begin
            done = 1;
            for (int m = 0; m < NM; m++) begin
                want = (rem[m] > 0) && !drop[m];
                drive_m(m, want, want, 1'b0, 32'h3000 + 32'(m), 32'h0, 3'b000);
                if (rem[m] > 0) done = 0;
            end
            if (done) break;
            settle();
            if (grant != '0 && grant != prev) glog.push_back(grant);
            prev = grant;
            for (int m = 0; m < NM; m++) begin
                drop[m] = m_ack[m];
                if (m_ack[m]) rem[m]--;
            end
            step();
        end
        chk("rr_completed", 128'(done), 128'(1'b1));
        auto_ack = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [NM-1:0] e2[8];
        logic [NM-1:0] e3[6];
        logic [10:0]   e_stb, e_to, l_stb, l_to, l_err;
        logic [NM-1:0] ack_seen;

        rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        s_dat_i = '0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0;
        m_stb = '0; m_cti = '0; m_bte = '0;
        step();
        step();
        rst = 1'b0;

        // Single read from master 0 with one wait state
        drive_m(0, 1, 1, 0, 32'h1000, 32'h0, 3'b000);
        settle(); chk("t1_c1_idle", 128'(grant), 128'(3'b000));
        step();
        settle(); chk("t1_c2_grant", 128'(grant), 128'(3'b001));
        chk("t1_c2_cyc", 128'(s_cyc), 128'(1'b1));
        chk("t1_c2_adr", 128'(s_adr), 128'(32'h1000));
        step();
        man_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
        settle(); chk("t1_c3_ack", 128'(m_ack), 128'(3'b001));
        chk("t1_c3_dat", 128'(m_dat_o[31:0]), 128'(32'hDEADBEEF));
        step();
        man_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        settle(); chk("t1_c4_held", 128'(grant), 128'(3'b001));
        step();
        settle(); chk("t1_c5_idle", 128'(grant), 128'(3'b000));
        step();

        // Simultaneous requests after reset
        do_reset();
        drive_m(0, 1, 1, 0, 32'h1010, 32'h0, 3'b000);
        drive_m(1, 1, 1, 0, 32'h1020, 32'h0, 3'b000);
        step();
        man_ack = 1'b1;
        settle(); chk("t2_first_grant", 128'(grant), 128'(3'b001));
        chk("t2_ack_m0_only", 128'(m_ack), 128'(3'b001));
        step();
        man_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        step();
        settle(); chk("t2_gap_idle", 128'(grant), 128'(3'b000));
        step();
        man_ack = 1'b1;
        settle(); chk("t2_second_grant", 128'(grant), 128'(3'b010));
        chk("t2_ack_m1", 128'(m_ack), 128'(3'b010));
        step();
        man_ack = 1'b0; drive_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        step();
        step();

        // Round-robin alternation
        e2 = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        run_rr(3'b011, 4);
        chk("rr2_count", 128'(glog.size()), 128'(8));
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("rr2_grant%0d", i), 128'(glog[i]), 128'(e2[i]));
        do_reset();
        e3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        run_rr(3'b111, 2);
        chk("rr3_count", 128'(glog.size()), 128'(6));
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk($sformatf("rr3_grant%0d", i), 128'(glog[i]), 128'(e3[i]));

        // Master 1 burst holds the grant while master 0 waits
        drive_m(1, 1, 1, 0, 32'h2000, 32'h0, 3'b010);
        step();
        drive_m(0, 1, 1, 0, 32'h1100, 32'h0, 3'b000);
        man_ack = 1'b1;
        settle(); chk("t4_grant_m1", 128'(grant), 128'(3'b010));
        chk("t4_beat1_ack", 128'(m_ack), 128'(3'b010));
        chk("t4_cti_inc", 128'(s_cti), 128'(3'b010));
        step();
        drive_m(1, 1, 1, 0, 32'h2004, 32'h0, 3'b010);
        settle(); chk("t4_beat2_ack", 128'(m_ack), 128'(3'b010));
        step();
        drive_m(1, 1, 1, 0, 32'h2008, 32'h0, 3'b010);
        step();
        drive_m(1, 1, 1, 0, 32'h200C, 32'h0, 3'b111);
        settle(); chk("t4_beat4_grant", 128'(grant), 128'(3'b010));
        chk("t4_cti_end", 128'(s_cti), 128'(3'b111));
        chk("t4_beat4_adr", 128'(s_adr), 128'(32'h200C));
        step();
        man_ack = 1'b0; drive_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        settle(); chk("t4_drop_held", 128'(grant), 128'(3'b010));
        step();
        settle(); chk("t4_gap_idle", 128'(grant), 128'(3'b000));
        step();
        man_ack = 1'b1;
        settle(); chk("t4_grant_m0", 128'(grant), 128'(3'b001));
        chk("t4_ack_m0", 128'(m_ack), 128'(3'b001));
        step();
        man_ack = 1'b0; drive_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        step();
        step();

        // Watchdog with TIMEOUT=4 and a silent slave; a late ack lands in the timeout cycle
        e_stb = 11'b10111101111;
        e_to  = 11'b01000010000;
        ack_seen = '0;
        drive_m(0, 1, 1, 1, 32'h4000, 32'hA5A5A5A5, 3'b000);
        step();
        for (int k = 0; k < 11; k++) begin
            man_ack = (k == 4);
            settle();
            l_stb[k] = s_stb;
            l_to[k]  = tmo;
            l_err[k] = m_err[0];
            ack_seen = ack_seen | m_ack;
            step();
        end
        man_ack = 1'b0;
        chk("t5_stb_pattern", 128'(l_stb), 128'(e_stb));
        chk("t5_timeout_pattern", 128'(l_to), 128'(e_to));
        chk("t5_err_pattern", 128'(l_err), 128'(e_to));
        chk("t5_ack_suppressed", 128'(ack_seen), 128'(3'b000));
        drive_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        step();
        step();

        // Reset during a granted write
        drive_m(0, 1, 1, 1, 32'h5000, 32'h12345678, 3'b000);
        step();
        rst = 1'b1;
        settle(); chk("t6_pre_grant", 128'(grant), 128'(3'b001));
        chk("t6_pre_we", 128'(s_we), 128'(1'b1));
        step();
        rst = 1'b0;
        drive_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        drive_m(1, 1, 1, 0, 32'h6000, 32'h0, 3'b000);
        man_ack = 1'b1; s_err = 1'b1;
        settle(); chk("t6_grant_dropped", 128'(grant), 128'(3'b000));
        chk("t6_cyc_dropped", 128'(s_cyc), 128'(1'b0));
        chk("t6_no_resp", 128'({m_ack, m_err}), 128'(6'b000000));
        step();
        s_err = 1'b0;
        settle(); chk("t6_m1_grant", 128'(grant), 128'(3'b010));
        chk("t6_m1_ack", 128'(m_ack), 128'(3'b010));
        step();
        man_ack = 1'b0; drive_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_io_arbiter.md
# wb_io_arbiter

Round-robin Wishbone B3 arbiter that shares the single `wb_io` master port of the peripheral interconnect among `num_masters` bus masters (CPU data port, DMA/VGA fetch engine). It grants the bus for a whole `cyc` period, so bursts and read-modify-write sequences are never split. It routes slave responses only to the granted master. A watchdog terminates any access that a peripheral fails to acknowledge within `TIMEOUT` cycles.

## Interface
- `num_masters`, default 2, number of requesting masters (2..8).
- `TIMEOUT`, default 255, maximum cycles a strobed access may wait for ack/err/rty (≥2).
- `wb_clk_i`  in  1  system clock; everything is sampled on its rising edge.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `wbm_adr_i`  in  32*num_masters  master addresses; master m occupies bits [32m+31:32m].
- `wbm_dat_i`  in  32*num_masters  master write data.
- `wbm_sel_i`  in  4*num_masters  byte selects.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i`  in  num_masters  per-master control.
- `wbm_cti_i`  in  3*num_masters  cycle type identifiers.
- `wbm_bte_i`  in  2*num_masters  burst type extensions.
- `wbm_dat_o`  out  32*num_masters  read data; `wbs_dat_i` broadcast to every slice.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o`  out  num_masters  responses, granted master only.
- `wbs_adr_o` / `wbs_dat_o` / `wbs_sel_o` / `wbs_we_o` / `wbs_cyc_o` / `wbs_stb_o` / `wbs_cti_o` / `wbs_bte_o`  out  32/32/4/1/1/1/3/2  signals to the interconnect `wb_io` port.
- `wbs_dat_i`  in  32  interconnect read data.
- `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i`  in  1  interconnect responses.
- `grant_o`  out  num_masters  one-hot registered grant; all zero when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Two states:
  - IDLE: `grant_o` = 0.
  - BUSY: exactly one `grant_o` bit is set.
- IDLE → BUSY: if any `wbm_cyc_i` is high, grant the first requester found by searching upward (modulo `num_masters`) from `last+1`. `last` is the most recent grantee; its reset value is `num_masters-1`, so master 0 wins first.
- BUSY → IDLE: when the granted master's `wbm_cyc_i` is low. `last` is updated to that master.
- Requests from non-granted masters are ignored while BUSY; they receive no ack/err/rty.
- BUSY forwarding (combinational from the granted slice):
  - adr/dat/sel/we/cyc/cti/bte are forwarded.
  - `wbs_stb_o` = granted `wbm_stb_i`, except it is forced to 0 in the timeout cycle.
  - `wbm_ack_o`, `wbm_rty_o` = slave response gated by `grant_o`.
  - `wbm_err_o` = (`wbs_err_i` | timeout) gated by `grant_o`.
- IDLE: every `wbs_*` output and every `wbm_ack/err/rty_o` is 0.
- Bursts: the grant is held through any cti sequence (010 … 111) until `cyc` drops. cti and bte pass through unchanged.
- Watchdog counter (width clog2(TIMEOUT+1)):
  - Clears in IDLE, on any of `wbs_ack_i`/`wbs_err_i`/`wbs_rty_i`, and when `wbs_stb_o` is low.
  - Otherwise increments each cycle.
  - When the count equals TIMEOUT-1 while stb is still unanswered, the next cycle is the timeout cycle:
    - `timeout_o` = 1 and `wbm_err_o[g]` = 1.
    - `wbs_stb_o` = 0 so the slave sees the access withdrawn.
    - The counter clears.
  - The master may retry or drop `cyc`.
- A slave response arriving in the timeout cycle is suppressed. Only err is returned.

## Timing
- Reset (synchronous) forces:
  - state IDLE, `grant_o` = 0, `last` = num_masters-1, counter 0, `timeout_o` = 0.
  - All `wbs_*` outputs and `wbm_ack/err/rty_o` are 0.
  - `wbm_dat_o` still mirrors `wbs_dat_i`.
- Reset asserted mid-access drops the grant at that edge. No response reaches the master after the reset edge.
- Grant latency: `cyc` rising in cycle n → `grant_o` and `wbs_cyc_o` high in cycle n+1.
- The ack path is combinational. A zero-wait slave acks in cycle n+1, and the master sees `wbm_ack_o` in the same cycle.
- Handover:
  - The granted master drops `cyc` in cycle k → IDLE in k+1.
  - The next requester is granted in k+2, giving one idle bus cycle between owners.
- Simultaneous requests: resolved purely by round-robin order from `last`. There is no fixed priority beyond the reset value of `last`.
- Same-master re-request: a master that drops and immediately re-raises `cyc` while another master is waiting loses the next grant to that master.
- Timeout fires exactly TIMEOUT cycles after `wbs_stb_o` first goes high without a response.

## Test plan
- Single read, master 0 only: cyc/stb at cycle 1, adr 0x1000, slave acks at cycle 3 with dat 0xDEADBEEF → `grant_o` = 01 at cycle 2; `wbm_ack_o[0]` at cycle 3; `wbm_dat_o[31:0]` = 0xDEADBEEF; IDLE at cycle 5 after cyc drops at 4.
- Masters 0 and 1 raise cyc in the same cycle after reset → master 0 granted first. Master 1 is granted two cycles after master 0 drops cyc and sees no ack meanwhile.
- Both masters request continuously for 4 transactions each → grants alternate 01, 10, 01, 10. With num_masters=3 and all requesting, the order is 0, 1, 2, 0.
- Master 1 runs a 4-beat incrementing burst (cti 010 ×3 then 111) while master 0 requests → grant stays 10 through all four acks; master 0 is granted only after master 1 drops cyc.
- TIMEOUT=4, slave never responds → `wbs_stb_o` high for 4 cycles then low for 1; `timeout_o` and `wbm_err_o[g]` pulse for exactly 1 cycle; counter restarts if the master keeps stb high.
- Reset asserted during a granted write before ack → next cycle `grant_o` = 0, `wbs_cyc_o` = 0, no ack or err delivered; first post-reset request from master 1 alone is granted normally.
